// File: rtl/grf_pkg.sv
// Shared constants and helpers for the multi-port general register file.
package grf_pkg;

  localparam int REG_ZERO  = 0;
  localparam int DEF_DW    = 32;
  localparam int DEF_NREGS = 32;

  // Ceiling log2 for tools without $clog2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  localparam int DEF_AW = clog2(DEF_NREGS);

endpackage

// File: rtl/grf_mp_if.sv
// Read, write and issue bus of the multi-port register file.
interface grf_mp_if
  import grf_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NREGS = DEF_NREGS,
  parameter int NR    = 2,
  parameter int NW    = 1
);
  localparam int AW = clog2(NREGS);

  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic [AW:0]      busy_cnt;

  modport master (
    output raddr, we, waddr, wdata, iss_en, iss_addr,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, we, waddr, wdata, iss_en, iss_addr,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/grf_wsel.sv
// Write-port selector: reports whether any enabled write port targets i_addr
// and returns the data of the highest-index matching port.
module grf_wsel
  import grf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NW = 1
) (
  input  logic [AW-1:0]    i_addr,
  input  logic [NW-1:0]    i_we,
  input  logic [NW*AW-1:0] i_waddr,
  input  logic [NW*DW-1:0] i_wdata,
  output logic             o_hit,
  output logic [DW-1:0]    o_data
);

  // Ascending scan so the last (highest-index) match overrides earlier ones.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int j = 0; j < NW; j++) begin
      if (i_we[j] && (i_waddr[j*AW +: AW] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wdata[j*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file with write-through bypass and a
// per-register busy scoreboard for ID-stage hazard detection.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREGS    = DEF_NREGS,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic     clk,
  input  logic     reset,
  grf_mp_if.slave  bus
);

  localparam int AW = clog2(NREGS);

  logic [DW-1:0]    r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busyCnt;

  logic [NREGS-1:0] w_regHit;
  logic [DW-1:0]    w_regData [NREGS];
  logic [NREGS-1:0] w_busyNext;
  logic [AW:0]      w_busyCntNext;

  logic [NR-1:0]    w_rdHit;
  logic [DW-1:0]    w_rdData [NR];
  logic [NR*DW-1:0] w_rdata;
  logic [NR-1:0]    w_rbusy;

  // One selector per register resolves both the write value and the busy clear.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    grf_wsel #(.DW(DW), .AW(AW), .NW(NW)) u_wsel (
      .i_addr  (AW'(r)),
      .i_we    (bus.we),
      .i_waddr (bus.waddr),
      .i_wdata (bus.wdata),
      .o_hit   (w_regHit[r]),
      .o_data  (w_regData[r])
    );
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    grf_wsel #(.DW(DW), .AW(AW), .NW(NW)) u_wsel (
      .i_addr  (bus.raddr[k*AW +: AW]),
      .i_we    (bus.we),
      .i_waddr (bus.waddr),
      .i_wdata (bus.wdata),
      .o_hit   (w_rdHit[k]),
      .o_data  (w_rdData[k])
    );
  end

  // Issue dominates retirement so a back-to-back producer keeps the register busy.
  always_comb begin
    w_busyNext    = r_busy;
    w_busyCntNext = '0;
    for (int r = 0; r < NREGS; r++) begin
      if ((ZERO_REG != 0) && (r == REG_ZERO)) begin
        w_busyNext[r] = 1'b0;
      end else if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
        w_busyNext[r] = 1'b1;
      end else if (w_regHit[r]) begin
        w_busyNext[r] = 1'b0;
      end
      w_busyCntNext = w_busyCntNext + {{AW{1'b0}}, w_busyNext[r]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_regHit[r] && !((ZERO_REG != 0) && (r == REG_ZERO))) begin
          r_regs[r] <= w_regData[r];
        end
      end
      r_busy    <= w_busyNext;
      r_busyCnt <= w_busyCntNext;
    end
  end

  // A bypassed write hides the busy bit unless the same register is re-issued.
  always_comb begin
    logic [AW-1:0] w_ra;
    logic          w_issHit;
    w_rdata  = '0;
    w_rbusy  = '0;
    w_ra     = '0;
    w_issHit = 1'b0;
    for (int k = 0; k < NR; k++) begin
      w_ra     = bus.raddr[k*AW +: AW];
      w_issHit = bus.iss_en && (bus.iss_addr == w_ra);
      if (!((ZERO_REG != 0) && (w_ra == AW'(REG_ZERO)))) begin
        if ((BYPASS != 0) && w_rdHit[k]) begin
          w_rdata[k*DW +: DW] = w_rdData[k];
        end else begin
          w_rdata[k*DW +: DW] = r_regs[w_ra];
        end
        w_rbusy[k] = r_busy[w_ra] && !((BYPASS != 0) && w_rdHit[k] && !w_issHit);
      end
    end
  end

  assign bus.rdata    = w_rdata;
  assign bus.rbusy    = w_rbusy;
  assign bus.busy_cnt = r_busyCnt;

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench: a bypassing (A) and a non-bypassing (B) register file share
// identical stimulus, NW = 2, NR = 2, 32 x 32-bit, register 0 hardwired.
module tb_grf_mp;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] expA0;
    logic [31:0] expA1;
    logic [31:0] expB0;
    logic [31:0] expB1;
    logic [1:0]  expABusy;
    logic [1:0]  expBBusy;
    logic [5:0]  expCnt;
  } vec_t;

  logic clk;
  logic reset;
  int   vecCount;
  int   missCount;
  vec_t vecs [15];

  grf_mp_if #(.DW(32), .NREGS(32), .NR(2), .NW(2)) busA ();
  grf_mp_if #(.DW(32), .NREGS(32), .NR(2), .NW(2)) busB ();

  assign busB.raddr    = busA.raddr;
  assign busB.we       = busA.we;
  assign busB.waddr    = busA.waddr;
  assign busB.wdata    = busA.wdata;
  assign busB.iss_en   = busA.iss_en;
  assign busB.iss_addr = busA.iss_addr;

  grf_mp #(.DW(32), .NREGS(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  grf_mp #(.DW(32), .NREGS(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(0)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    busA.we       = v.we;
    busA.waddr    = {v.wa1, v.wa0};
    busA.wdata    = {v.wd1, v.wd0};
    busA.iss_en   = v.iss;
    busA.iss_addr = v.ia;
    busA.raddr    = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d A.rdata0", idx), busA.rdata[31:0], v.expA0);
    checkOutput($sformatf("v%0d A.rdata1", idx), busA.rdata[63:32], v.expA1);
    checkOutput($sformatf("v%0d B.rdata0", idx), busB.rdata[31:0], v.expB0);
    checkOutput($sformatf("v%0d B.rdata1", idx), busB.rdata[63:32], v.expB1);
    checkOutput($sformatf("v%0d A.rbusy", idx), {30'd0, busA.rbusy}, {30'd0, v.expABusy});
    checkOutput($sformatf("v%0d B.rbusy", idx), {30'd0, busB.rbusy}, {30'd0, v.expBBusy});
    checkOutput($sformatf("v%0d busy_cnt", idx), {26'd0, busA.busy_cnt}, {26'd0, v.expCnt});
  endtask

  initial begin
    vec_t v;
    vecCount  = 0;
    missCount = 0;

    // Fields: we, wa0, wd0, wa1, wd1, iss, ia, ra0, ra1, A0, A1, B0, B1, Abusy, Bbusy, cnt
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd6,
                 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 6'd0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6,
                 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 2'b00, 2'b00, 6'd0};
    vecs[2]  = '{2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2'b00, 2'b00, 6'd0};
    vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2'b00, 2'b00, 6'd0};
    vecs[4]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h22, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2'b00, 2'b00, 6'd0};
    vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 2'b00, 2'b00, 6'd0};
    vecs[6]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7,
                 32'h0, 32'h22, 32'h0, 32'h22, 2'b00, 2'b00, 6'd0};
    vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7,
                 32'h0, 32'h22, 32'h0, 32'h22, 2'b01, 2'b01, 6'd1};
    vecs[8]  = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h5, 1'b0, 5'd0, 5'd3, 5'd3,
                 32'h5, 32'h5, 32'h0, 32'h0, 2'b00, 2'b11, 6'd1};
    vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7,
                 32'h5, 32'h22, 32'h5, 32'h22, 2'b00, 2'b00, 6'd0};
    vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3,
                 32'h0, 32'h5, 32'h0, 32'h5, 2'b00, 2'b00, 6'd0};
    vecs[11] = '{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3,
                 32'h99, 32'h5, 32'h0, 32'h5, 2'b01, 2'b01, 6'd1};
    vecs[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3,
                 32'h99, 32'h5, 32'h99, 32'h5, 2'b01, 2'b01, 6'd1};
    vecs[13] = '{2'b11, 5'd3, 32'h0, 5'd9, 32'hAA, 1'b0, 5'd0, 5'd9, 5'd3,
                 32'hAA, 32'h0, 32'h99, 32'h5, 2'b00, 2'b01, 6'd1};
    vecs[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3,
                 32'hAA, 32'h0, 32'hAA, 32'h0, 2'b00, 2'b00, 6'd0};

    v = vecs[3];
    v.ra0 = 5'd5;
    applyStimulus(v);
    reset = 1'b1;
    #12;
    checkOutput("reset A.rdata0", busA.rdata[31:0], 32'h0);
    checkOutput("reset B.rdata0", busB.rdata[31:0], 32'h0);
    checkOutput("reset rbusy", {30'd0, busA.rbusy}, 32'h0);
    checkOutput("reset busy_cnt", {26'd0, busA.busy_cnt}, 32'h0);
    #1 reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkVector(i, vecs[i]);
      tick();
    end

    // Asynchronous reset mid-cycle with r5 written and busy.
    v = vecs[3];
    v.we = 2'b01; v.wa0 = 5'd5; v.wd0 = 32'hDEADBEEF; v.iss = 1'b1; v.ia = 5'd5;
    v.ra0 = 5'd5; v.ra1 = 5'd9;
    applyStimulus(v);
    tick();
    v.we = 2'b00; v.iss = 1'b0;
    applyStimulus(v);
    #2;
    checkOutput("pre-reset r5", busA.rdata[31:0], 32'hDEADBEEF);
    checkOutput("pre-reset busy_cnt", {26'd0, busA.busy_cnt}, 32'd1);
    checkOutput("pre-reset rbusy", {30'd0, busA.rbusy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset A.r5", busA.rdata[31:0], 32'h0);
    checkOutput("async reset B.r5", busB.rdata[31:0], 32'h0);
    checkOutput("async reset A.r9", busA.rdata[63:32], 32'h0);
    checkOutput("async reset busy_cnt", {26'd0, busA.busy_cnt}, 32'h0);
    checkOutput("async reset rbusy", {30'd0, busA.rbusy}, 32'h0);
    v.we = 2'b01; v.wd0 = 32'h1; v.iss = 1'b1;
    applyStimulus(v);
    #1;
    checkOutput("held reset B.r5", busB.rdata[31:0], 32'h0);
    tick();
    v.we = 2'b00; v.iss = 1'b0;
    applyStimulus(v);
    #2;
    checkOutput("reset edge A.r5", busA.rdata[31:0], 32'h0);
    checkOutput("reset edge busy_cnt", {26'd0, busA.busy_cnt}, 32'h0);
    checkOutput("reset edge rbusy", {30'd0, busA.rbusy}, 32'h0);
    reset = 1'b0;
    tick();
    #2;
    checkOutput("post-reset A.r5", busA.rdata[31:0], 32'h0);
    checkOutput("post-reset busy_cnt", {26'd0, busA.busy_cnt}, 32'h0);

    // Issue every writable register, then retire them in order.
    v = vecs[3];
    for (int i = 1; i < 32; i++) begin
      v.iss = 1'b1;
      v.ia  = 5'(i);
      applyStimulus(v);
      tick();
      if (i == 16) checkOutput("sweep busy_cnt mid", {26'd0, busA.busy_cnt}, 32'd16);
    end
    v.iss = 1'b0;
    applyStimulus(v);
    #2;
    checkOutput("sweep busy_cnt full", {26'd0, busA.busy_cnt}, 32'd31);
    for (int i = 1; i < 32; i++) begin
      v.we = 2'b01; v.wa0 = 5'(i); v.wd0 = 32'(i);
      v.ra0 = 5'(i); v.ra1 = 5'(i);
      applyStimulus(v);
      #2;
      checkOutput($sformatf("sweep bypass r%0d", i), busA.rdata[31:0], 32'(i));
      checkOutput($sformatf("sweep A.rbusy r%0d", i), {30'd0, busA.rbusy}, 32'd0);
      checkOutput($sformatf("sweep B.rbusy r%0d", i), {30'd0, busB.rbusy}, 32'd3);
      checkOutput($sformatf("sweep busy_cnt r%0d", i), {26'd0, busA.busy_cnt}, 32'(32 - i));
      tick();
    end
    v.we = 2'b00;
    applyStimulus(v);
    #2;
    checkOutput("sweep busy_cnt end", {26'd0, busA.busy_cnt}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      v.ra0 = 5'(i);
      v.ra1 = 5'(32 - i);
      applyStimulus(v);
      #1;
      checkOutput($sformatf("sweep A.read r%0d", i), busA.rdata[31:0], 32'(i));
      checkOutput($sformatf("sweep B.read r%0d", 32 - i), busB.rdata[63:32], 32'(32 - i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor to the single-write, two-read GRF in the CPU pipeline.
- Sits in the ID stage. It provides:
  - NR combinational read ports with optional write-through bypass from all NW write ports.
  - A per-register busy scoreboard. Producers set busy at issue and the write port clears it, giving hazard logic a direct stall source.

Parameters:
- DW, 32, data width in bits.
- NREGS, 32, number of registers (power of two, >= 2); AW = $clog2(NREGS).
- NR, 2, number of read ports (>= 1).
- NW, 1, number of write ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never busy).
- BYPASS, 1, 1 = read ports return same-cycle write data.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers and busy bits.
- raddr  input  NR*AW  read addresses, port k at [k*AW +: AW].
- rdata  output  NR*DW  read data, port k at [k*DW +: DW].
- rbusy  output  NR  1 = register addressed by port k has an outstanding producer.
- we  input  NW  write enables.
- waddr  input  NW*AW  write addresses.
- wdata  input  NW*DW  write data.
- iss_en  input  1  issue strobe: mark iss_addr busy.
- iss_addr  input  AW  destination register of issued instruction.
- busy_cnt  output  AW+1  registered population count of busy bits.

Behaviour:
- Reset (async, any time, including mid-write or mid-issue):
  - All registers = 0, all busy bits = 0, busy_cnt = 0, immediately.
  - rdata then reads 0 unless bypass applies.
- Write, at posedge when we[j] = 1:
  - reg[waddr j] <= wdata j.
  - Address 0 is ignored when ZERO_REG = 1.
  - Several ports hitting the same address in one cycle: the highest index j wins.
- Read (combinational, zero latency): the first matching rule applies.
  - raddr = 0 and ZERO_REG = 1 -> rdata = 0.
  - BYPASS = 1 and some we[j] with waddr j = raddr -> wdata of the highest matching j.
  - Otherwise -> stored value.
  - BYPASS = 0 -> stored value only; the new value is visible the cycle after the write.
- Scoreboard next state per register r, evaluated at posedge:
  - set = iss_en and iss_addr = r.
  - clr = any we[j] with waddr j = r.
  - busy_next = set ? 1 : (clr ? 0 : busy).
  - Set dominates clear: a new producer is issued while the old one retires.
  - iss_en to address 0 with ZERO_REG = 1 is ignored.
  - A clear with busy already 0 is legal, a no-op.
  - Setting an already-busy register is legal; busy stays 1 and there is no counting.
- rbusy k = busy[raddr k] and not (BYPASS = 1 and a current write hits raddr k and not (iss_en and iss_addr = raddr k)).
  - The write-hit term only reaches rbusy when BYPASS = 1; with BYPASS = 0, rbusy k = busy[raddr k].
  - Port reading address 0 with ZERO_REG = 1 -> rbusy = 0.
- busy_cnt: registered, equals the number of set busy bits after each posedge; range 0..NREGS.
- No X propagation: every rdata is defined for every address; NREGS must be a power of two, so all addresses are valid.

Decomposition:
- Shared package grf_pkg:
  - Constants REG_ZERO = 0 and default DW/NREGS.
  - Function clog2 for use where the tool lacks $clog2.
  - Typedef-equivalent localparams for AW.
- One natural sub-module: grf_wsel (combinational, parameter NW).
  - Given an address, it returns hit and the winning highest-index write data.
  - It is instantiated once per read port for the bypass path and per register for the write/clear path.
- Storage, scoreboard and popcount stay in grf_mp.

Test Plan:
- Reset mid-activity: write 0xDEADBEEF to r5, assert reset asynchronously between edges -> rdata for r5 = 0 and busy_cnt = 0 before the next edge; state stays cleared through the following edge.
- Zero register: we = 1, waddr = 0, wdata = 0x12345678; iss_en to r0 -> r0 reads 0, rbusy = 0, busy_cnt unchanged.
- Bypass and priority (NW = 2): same cycle port0 writes r7 = 0x11, port1 writes r7 = 0x22.
  - BYPASS = 1: rdata = 0x22 in the same cycle, and r7 = 0x22 after the edge.
  - BYPASS = 0: rdata = old value, then 0x22 the next cycle.
- Scoreboard lifecycle: issue r3 -> rbusy = 1 and busy_cnt = 1 next cycle; write r3 = 0x5 -> same-cycle rbusy = 0 (BYPASS = 1) and busy_cnt = 0 after the edge.
- Set-over-clear: r9 busy; same cycle write r9 and iss_en r9 -> r9 stays busy, rbusy = 1 during that cycle, busy_cnt unchanged.
- Full sweep: issue r1..r31 on consecutive cycles -> busy_cnt reaches 31; write r1..r31 with value = index -> each read returns its index; busy_cnt ends at 0.
